// File: rtl/dsm_pkg.sv
// Shared constants and types for the second-order delta-sigma DAC modulator.
package dsm_pkg;
  localparam int          FS        = 32768;
  localparam logic [15:0] MIDSCALE  = 16'h8000;
  localparam int          DSM_IW    = 24;
  localparam int          DSM_CLAMP = 26214;
  localparam int          DSM_LIMIT = 2097152;

  typedef logic signed [DSM_IW-1:0] integ_t;
endpackage

// File: rtl/sigma_delta_dac_modulator_if.sv
// Sample/control bus between the sample source and the DAC modulator.
interface sigma_delta_dac_modulator_if;
  logic [15:0] dec_rate;
  logic [15:0] DATA;
  logic        data_en;
  logic        sample_req;
  logic        mdata1;
  logic        underrun;
  logic        overload;

  modport master (
    output dec_rate, DATA, data_en,
    input  sample_req, mdata1, underrun, overload
  );

  modport slave (
    input  dec_rate, DATA, data_en,
    output sample_req, mdata1, underrun, overload
  );
endinterface

// File: rtl/dsm2_core.sv
// Second-order CIFB modulator: input clamp, two integrators, 1-bit quantizer
// and overload recovery that clears both integrators.
module dsm2_core
  import dsm_pkg::*;
#(
  parameter int IW    = DSM_IW,
  parameter int CLAMP = DSM_CLAMP,
  parameter int LIMIT = DSM_LIMIT
) (
  input  logic        mclk1,
  input  logic        reset,
  input  logic [15:0] active,
  output logic        mdata1,
  output logic        overload
);
  localparam logic signed [IW-1:0] FS_W    = IW'(FS);
  localparam logic signed [IW-1:0] CLAMP_W = IW'(CLAMP);
  localparam logic signed [IW-1:0] LIMIT_W = IW'(LIMIT);

  logic signed [IW-1:0] int1_reg, int2_reg;
  logic signed [IW-1:0] x_raw, x, v, int1_next, int2_next;
  logic                 y, ovf;

  always_comb begin
    x_raw = $signed({{(IW-16){1'b0}}, active}) - FS_W;
    if (x_raw > CLAMP_W)
      x = CLAMP_W;
    else if (x_raw < -CLAMP_W)
      x = -CLAMP_W;
    else
      x = x_raw;

    y         = ~int2_reg[IW-1];
    v         = y ? FS_W : -FS_W;
    int1_next = int1_reg + x - v;
    int2_next = int2_reg + int1_next - v;
    ovf       = (int1_next > LIMIT_W) || (int1_next < -LIMIT_W) ||
                (int2_next > LIMIT_W) || (int2_next < -LIMIT_W);
  end

  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      int1_reg <= '0;
      int2_reg <= '0;
      mdata1   <= 1'b0;
      overload <= 1'b0;
    end else begin
      mdata1   <= y;
      overload <= ovf;
      // Recovery restarts from zero state, so the next output bit is a 1.
      if (ovf) begin
        int1_reg <= '0;
        int2_reg <= '0;
      end else begin
        int1_reg <= int1_next;
        int2_reg <= int2_next;
      end
    end
  end
endmodule

// File: rtl/sigma_delta_dac_modulator.sv
// Delta-sigma DAC front end: sample-period scheduler (counter plus
// pending/active register pair) feeding the second-order modulator core.
module sigma_delta_dac_modulator
  import dsm_pkg::*;
#(
  parameter int IW    = DSM_IW,
  parameter int CLAMP = DSM_CLAMP,
  parameter int LIMIT = DSM_LIMIT
) (
  input  logic                        mclk1,
  input  logic                        reset,
  sigma_delta_dac_modulator_if.slave  bus
);
  logic [15:0] counter_reg, period_m1;
  logic        boundary;
  logic [15:0] pending_reg, active_reg;
  logic        pending_valid_reg, primed_reg;
  logic        sample_req_reg, underrun_reg;
  logic        core_mdata1, core_overload;

  // ">=" rather than "==" so a shrinking dec_rate wraps at the next edge.
  always_comb begin
    period_m1 = (bus.dec_rate < 16'd2) ? 16'd1 : bus.dec_rate - 16'd1;
    boundary  = (counter_reg >= period_m1);
  end

  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      counter_reg       <= '0;
      sample_req_reg    <= 1'b0;
      underrun_reg      <= 1'b0;
      pending_reg       <= MIDSCALE;
      pending_valid_reg <= 1'b0;
      active_reg        <= MIDSCALE;
      primed_reg        <= 1'b0;
    end else begin
      counter_reg    <= boundary ? '0 : counter_reg + 16'd1;
      sample_req_reg <= boundary;
      underrun_reg   <= boundary && !pending_valid_reg && primed_reg;

      if (boundary && pending_valid_reg) begin
        active_reg <= pending_reg;
        primed_reg <= 1'b1;
      end

      // A strobe on the boundary cycle stays pending for the next period.
      if (bus.data_en) begin
        pending_reg       <= bus.DATA;
        pending_valid_reg <= 1'b1;
      end else if (boundary) begin
        pending_valid_reg <= 1'b0;
      end
    end
  end

  dsm2_core #(
    .IW    (IW),
    .CLAMP (CLAMP),
    .LIMIT (LIMIT)
  ) u_core (
    .mclk1    (mclk1),
    .reset    (reset),
    .active   (active_reg),
    .mdata1   (core_mdata1),
    .overload (core_overload)
  );

  assign bus.sample_req = sample_req_reg;
  assign bus.underrun   = underrun_reg;
  assign bus.mdata1     = core_mdata1;
  assign bus.overload   = core_overload;
endmodule

// File: tb/tb_sigma_delta_dac_modulator.sv
// Bench for the delta-sigma DAC modulator: two instances (default and
// overload-prone parameters) against a cycle-level arithmetic reference.
module tb_sigma_delta_dac_modulator;
  logic        mclk1 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dec_rate = 16'd256;
  logic [15:0] data = 16'h8000;
  logic        data_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  sigma_delta_dac_modulator_if bus0();
  sigma_delta_dac_modulator_if bus1();

  assign bus0.dec_rate = dec_rate;
  assign bus0.DATA     = data;
  assign bus0.data_en  = data_en;
  assign bus1.dec_rate = dec_rate;
  assign bus1.DATA     = data;
  assign bus1.data_en  = data_en;

  sigma_delta_dac_modulator dut0 (.mclk1(mclk1), .reset(reset), .bus(bus0));
  sigma_delta_dac_modulator #(.CLAMP(32767), .LIMIT(131072)) dut1 (
    .mclk1(mclk1), .reset(reset), .bus(bus1));

  always #5 mclk1 = ~mclk1;

  // Observed {mdata1, sample_req, underrun, overload} per instance.
  logic [3:0] obs [2];
  always_comb begin
    obs[0] = {bus0.mdata1, bus0.sample_req, bus0.underrun, bus0.overload};
    obs[1] = {bus1.mdata1, bus1.sample_req, bus1.underrun, bus1.overload};
  end

  localparam int CLAMP_P [2] = '{26214, 32767};
  localparam int LIMIT_P [2] = '{2097152, 131072};

  int          m_cnt [2];
  int          m_i1 [2];
  int          m_i2 [2];
  logic [15:0] m_pend [2];
  logic [15:0] m_act [2];
  bit          m_pv [2];
  bit          m_primed [2];
  logic [3:0]  exp_out [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
      m_pend[k] = 16'h8000; m_act[k] = 16'h8000;
      m_pv[k] = 0; m_primed[k] = 0; exp_out[k] = 4'b0000;
    end
  endtask

  // Advance the reference by one clock using the inputs presented now.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int r, x, v, n1, n2;
      bit bnd, y, ov, ur;
      r   = (int'(dec_rate) < 2) ? 2 : int'(dec_rate);
      bnd = (m_cnt[k] >= r - 1);
      x   = int'(m_act[k]) - 32768;
      if (x > CLAMP_P[k]) x = CLAMP_P[k];
      if (x < -CLAMP_P[k]) x = -CLAMP_P[k];
      y   = (m_i2[k] >= 0);
      v   = y ? 32768 : -32768;
      n1  = m_i1[k] + x - v;
      n2  = m_i2[k] + n1 - v;
      ov  = (n1 > LIMIT_P[k]) || (n1 < -LIMIT_P[k]) ||
            (n2 > LIMIT_P[k]) || (n2 < -LIMIT_P[k]);
      m_i1[k] = ov ? 0 : n1;
      m_i2[k] = ov ? 0 : n2;
      ur = bnd && !m_pv[k] && m_primed[k];
      if (bnd && m_pv[k]) begin
        m_act[k] = m_pend[k];
        m_primed[k] = 1;
      end
      if (data_en) begin
        m_pend[k] = data;
        m_pv[k] = 1;
      end else if (bnd) begin
        m_pv[k] = 0;
      end
      m_cnt[k] = bnd ? 0 : m_cnt[k] + 1;
      exp_out[k] = {y, bnd, ur, ov};
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge mclk1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_en = 1'b0;
    @(posedge mclk1);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_held dut%0d got=%b exp=0000", k, obs[k]);
      end
    end
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_release dut%0d got=%b exp=0000", k, obs[k]);
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0] pat;
    int sr_cnt, sr_first, ur_cnt;
    pat = 8'b1001_1001;
    sr_cnt = 0; sr_first = -1; ur_cnt = 0;
    dec_rate = 16'd256;
    do_reset();
    for (int t = 1; t <= 520; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_out[k]) begin
          failures++;
          $display("FAIL idle dut%0d t=%0d got=%b exp=%b", k, t, obs[k], exp_out[k]);
        end
      end
      if (t <= 8) begin
        checks++;
        if (bus0.mdata1 !== pat[8-t]) begin
          failures++;
          $display("FAIL idle_pattern t=%0d got=%b exp=%b", t, bus0.mdata1, pat[8-t]);
        end
      end
      if (bus0.sample_req === 1'b1) begin
        sr_cnt++;
        if (sr_first < 0) sr_first = t;
      end
      if (bus0.underrun === 1'b1) ur_cnt++;
    end
    checks++;
    if (sr_cnt != 2 || sr_first != 256) begin
      failures++;
      $display("FAIL idle_sample_req count=%0d first=%0d exp count=2 first=256", sr_cnt, sr_first);
    end
    checks++;
    if (ur_cnt != 0) begin
      failures++;
      $display("FAIL idle_underrun got=%0d exp=0", ur_cnt);
    end
    $display("idle: %0d sample_req pulses, first at cycle %0d", sr_cnt, sr_first);
  endtask

  task automatic test_density(input logic [15:0] val, input int exp_ones);
    int ones, ur_cnt, ov_cnt;
    ones = 0; ur_cnt = 0; ov_cnt = 0;
    dec_rate = 16'd256;
    data = val;
    do_reset();
    data_en = 1'b1;
    for (int t = 1; t <= 258 + 4096; t++) begin
      tick();
      data_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_out[k]) begin
          failures++;
          $display("FAIL density_%h dut%0d t=%0d got=%b exp=%b", val, k, t, obs[k], exp_out[k]);
        end
      end
      if (bus0.sample_req === 1'b1) data_en = 1'b1;
      if (t > 258 && bus0.mdata1 === 1'b1) ones++;
      if (bus0.underrun === 1'b1) ur_cnt++;
      if (bus0.overload === 1'b1) ov_cnt++;
    end
    checks++;
    if (ones < exp_ones - 4 || ones > exp_ones + 4) begin
      failures++;
      $display("FAIL density_ones data=%h got=%0d exp=%0d+-4", val, ones, exp_ones);
    end
    checks++;
    if (ur_cnt != 0 || ov_cnt != 0) begin
      failures++;
      $display("FAIL density_flags data=%h underrun=%0d overload=%0d exp 0/0", val, ur_cnt, ov_cnt);
    end
    $display("density: data=%h ones=%0d/4096 expected %0d", val, ones, exp_ones);
  endtask

  task automatic test_underrun();
    int sr_cnt, ur_cnt, ur_first;
    sr_cnt = 0; ur_cnt = 0; ur_first = -1;
    dec_rate = 16'd16;
    data = 16'($urandom);
    do_reset();
    data_en = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      data_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_out[k]) begin
          failures++;
          $display("FAIL underrun dut%0d t=%0d got=%b exp=%b", k, t, obs[k], exp_out[k]);
        end
      end
      if (bus0.sample_req === 1'b1) sr_cnt++;
      if (bus0.underrun === 1'b1) begin
        ur_cnt++;
        if (ur_first < 0) ur_first = t;
      end
    end
    checks++;
    if (sr_cnt != 5 || ur_cnt != 4 || ur_first != 32) begin
      failures++;
      $display("FAIL underrun_count sr=%0d ur=%0d first=%0d exp sr=5 ur=4 first=32", sr_cnt, ur_cnt, ur_first);
    end
    $display("underrun: %0d boundaries, %0d underruns, first at cycle %0d", sr_cnt, ur_cnt, ur_first);
  endtask

  task automatic test_back_to_back();
    int ur_cnt;
    ur_cnt = 0;
    dec_rate = 16'd4;
    do_reset();
    for (int t = 1; t <= 400; t++) begin
      data_en = 1'b1;
      data = 16'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_out[k]) begin
          failures++;
          $display("FAIL back_to_back dut%0d t=%0d got=%b exp=%b", k, t, obs[k], exp_out[k]);
        end
      end
      if (bus0.underrun === 1'b1) ur_cnt++;
    end
    data_en = 1'b0;
    checks++;
    if (ur_cnt != 0) begin
      failures++;
      $display("FAIL back_to_back_underrun got=%0d exp=0", ur_cnt);
    end
    $display("back_to_back: 400 strobes at dec_rate=4");
  endtask

  task automatic test_overload();
    int ov0, ov1;
    bit prev_ov;
    ov0 = 0; ov1 = 0; prev_ov = 0;
    dec_rate = 16'd16;
    data = 16'hFFFF;
    do_reset();
    data_en = 1'b1;
    for (int t = 1; t <= 2000; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_out[k]) begin
          failures++;
          $display("FAIL overload dut%0d t=%0d got=%b exp=%b", k, t, obs[k], exp_out[k]);
        end
      end
      if (prev_ov) begin
        checks++;
        if (bus1.mdata1 !== 1'b1) begin
          failures++;
          $display("FAIL overload_resume t=%0d got=%b exp=1", t, bus1.mdata1);
        end
      end
      prev_ov = (bus1.overload === 1'b1);
      if (bus0.overload === 1'b1) ov0++;
      if (bus1.overload === 1'b1) ov1++;
    end
    data_en = 1'b0;
    checks++;
    if (ov0 != 0 || ov1 == 0) begin
      failures++;
      $display("FAIL overload_count dut0=%0d dut1=%0d exp dut0=0 dut1>0", ov0, ov1);
    end
    $display("overload: default=%0d pulses, tight-limit=%0d pulses", ov0, ov1);
  endtask

  task automatic test_random();
    dec_rate = 16'd8;
    do_reset();
    for (int t = 1; t <= 3000; t++) begin
      if (t % 250 == 1) dec_rate = 16'($urandom_range(0, 24));
      data_en = ($urandom_range(0, 3) == 0);
      data = 16'($urandom);
      if (t == 1500) begin
        reset = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obs[k] !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset dut%0d got=%b exp=0000", k, obs[k]);
          end
        end
        @(posedge mclk1);
        #1;
        model_reset();
        reset = 1'b0;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_out[k]) begin
          failures++;
          $display("FAIL random dut%0d t=%0d got=%b exp=%b", k, t, obs[k], exp_out[k]);
        end
      end
    end
    data_en = 1'b0;
    $display("random: 3000 cycles with varying dec_rate and a mid-run reset");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_density(16'hC000, 3072);
    test_density(16'hFFFF, 3686);
    test_density(16'h4000, 1024);
    test_underrun();
    test_back_to_back();
    test_overload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
